// File: rtl/regfile_wb_writer.sv
// regfile_wb_writer
//   Write-side initiator for the register file's single write port. Execute
//   results are accepted through a valid/ready handshake into a small in-order
//   queue and drained one entry per cycle into the register file whenever the
//   write port is not stalled. Pending (not yet written) results are forwarded
//   to the two read ports so operand fetch always sees the newest value.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     execute-stage result handshake
//   in_addr/in_data       destination register and result value
//   wb_stall              register file write port unavailable this cycle
//   we/waddr/wdata        register file write port (driven from queue head)
//   raddr1/raddr2         register file read addresses (snooped)
//   fwd_hit1/fwd_data1    newest pending write for raddr1
//   fwd_hit2/fwd_data2    newest pending write for raddr2
//   empty                 no pending writes
//
// Handshake: a transfer happens on a rising edge where in_valid and in_ready
// are both 1. in_ready depends only on the registered occupancy, never on
// in_valid or wb_stall, so a full queue does not reopen in the cycle it pops.
// in_valid may be held across cycles; in_addr/in_data must be stable while
// in_valid is high. Transfers to r0 complete but are dropped.
module regfile_wb_writer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wb_stall,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              fwd_hit1,
  output logic [DATA_W-1:0] fwd_data1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data2,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;
  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  slot;

  assign in_ready = (count != FULL);
  assign push     = in_valid & in_ready & (in_addr != '0);
  assign pop      = (count != '0) & ~wb_stall;
  assign empty    = (count == '0);

  // The register file samples the head on the same edge it is popped.
  assign we    = pop;
  assign waddr = empty ? '0 : mem_addr[rd_ptr];
  assign wdata = empty ? '0 : mem_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= in_addr;
      mem_data[wr_ptr] <= in_data;
    end
  end

  // Walk valid entries from oldest to newest; a later match overrides an
  // earlier one, so the newest pending value wins. The head still counts
  // even if it is being written this cycle.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    slot      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr + PTR_W'(i);
      if ((PTR_W+1)'(i) < count) begin
        if (raddr1 != '0 && mem_addr[slot] == raddr1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = mem_data[slot];
        end
        if (raddr2 != '0 && mem_addr[slot] == raddr2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = mem_data[slot];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_writer.sv
module tb_regfile_wb_writer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              wb_stall;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic              fwd_hit1;
  logic [DATA_W-1:0] fwd_data1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data2;
  logic              empty;

  int tests  = 0;
  int failed = 0;

  // Reference: the pending writes, oldest first, each packed as {addr, data}.
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  regfile_wb_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .wb_stall(wb_stall), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .empty(empty)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Newest pending write to register ra, or a miss.
  task automatic model_fwd(input logic [ADDR_W-1:0] ra, output logic hit, output logic [DATA_W-1:0] data);
    hit  = 1'b0;
    data = '0;
    if (ra != 0) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i][ADDR_W+DATA_W-1:DATA_W] == ra) begin
          hit  = 1'b1;
          data = exp_q[i][DATA_W-1:0];
          break;
        end
      end
    end
  endtask

  // Driver: called just after a falling edge. Drives one cycle of inputs,
  // checks every output against the model, then advances the model across
  // the rising edge and returns just after the next falling edge.
  task automatic step(input logic r, input logic v, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic st,
                      input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    logic              h;
    logic [DATA_W-1:0] fd;
    logic              has;
    logic              do_push;
    logic              do_pop;
    rst = r; in_valid = v; in_addr = a; in_data = d; wb_stall = st;
    raddr1 = r1; raddr2 = r2;
    #1;
    has = (exp_q.size() != 0);
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
    chk("empty", 32'(empty), 32'(!has));
    chk("we", 32'(we), 32'(has && !st));
    chk("waddr", 32'(waddr), has ? 32'(exp_q[0][ADDR_W+DATA_W-1:DATA_W]) : 32'd0);
    chk("wdata", wdata, has ? exp_q[0][DATA_W-1:0] : 32'd0);
    model_fwd(r1, h, fd);
    chk("fwd_hit1", 32'(fwd_hit1), 32'(h));
    chk("fwd_data1", fwd_data1, fd);
    model_fwd(r2, h, fd);
    chk("fwd_hit2", 32'(fwd_hit2), 32'(h));
    chk("fwd_data2", fwd_data2, fd);
    chk("count_bound", 32'(dut.count <= DEPTH), 32'd1);
    do_push = v && (exp_q.size() != DEPTH) && (a != 0);
    do_pop  = has && !st;
    @(posedge clk);
    if (r) exp_q.delete();
    else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({a, d});
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    wb_stall = 1'b0; raddr1 = '0; raddr2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state
    step(0, 0, 0, 0, 0, 0, 0);

    // Single write, one-cycle latency
    step(0, 1, 5'd3, 32'hDEADBEEF, 0, 5'd3, 0);
    chk("single_we", 32'(we), 32'd1);
    chk("single_waddr", 32'(waddr), 32'd3);
    chk("single_wdata", wdata, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 5'd3, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("single_empty", 32'(empty), 32'd1);

    // Fill under stall, hold a fifth push, then drain in order
    for (int i = 1; i <= 4; i++)
      step(0, 1, 5'(i), 32'(i * 'h11), 1, 5'(i), 5'd2);
    chk("full_ready", 32'(in_ready), 32'd0);
    step(0, 1, 5'd5, 32'h55, 1, 5'd1, 5'd4);
    for (int i = 0; i < 6; i++)
      step(0, 1, 5'd5, 32'h55, 0, 5'd5, 5'd4);
    step(0, 0, 0, 0, 0, 0, 0);

    // r0 discard
    step(0, 1, 5'd0, 32'h1234, 0, 5'd0, 5'd0);
    step(0, 0, 0, 0, 0, 5'd0, 0);
    chk("r0_empty", 32'(empty), 32'd1);

    // Forward newest of two writes to one register
    step(0, 1, 5'd5, 32'hA, 1, 5'd5, 5'd6);
    step(0, 1, 5'd5, 32'hB, 1, 5'd5, 5'd6);
    step(0, 0, 0, 0, 1, 5'd5, 5'd6);
    step(0, 0, 0, 0, 0, 5'd5, 5'd6);
    step(0, 0, 0, 0, 0, 5'd5, 5'd6);

    // Concurrent push/pop at count=2, then wrap pointers several times
    step(0, 1, 5'd7, 32'h700, 1, 5'd7, 5'd8);
    step(0, 1, 5'd8, 32'h800, 1, 5'd7, 5'd8);
    for (int i = 0; i < 3 * DEPTH; i++)
      step(0, 1, 5'(9 + i), 32'(32'h900 + i), 0, 5'(8 + i), 5'(9 + i));
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 0, 0, 0);

    // Reset mid-drain
    for (int i = 0; i < 3; i++)
      step(0, 1, 5'(20 + i), 32'(32'hC0 + i), 1, 5'd20, 5'd22);
    step(1, 1, 5'd23, 32'hC3, 0, 5'd20, 5'd22);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 0, 5'd20, 5'd22);
    chk("post_rst_empty", 32'(empty), 32'd1);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 99) < 70),
           5'($urandom_range(0, 7)),
           $urandom,
           ($urandom_range(0, 99) < 40),
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
